// File: rtl/riscv_fetch.sv
// Instruction fetch stage: one outstanding imem request, DEPTH-entry instruction FIFO,
// redirect with stale-response discard. RISCV_FETCH_BUBBLE_CNT_EN enables the bubble counter.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_valid_out,
    output logic [31:0] imem_req_addr_out,
    input  logic        imem_req_ready_in,
    input  logic        imem_resp_valid_in,
    input  logic [31:0] imem_resp_data_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    input  logic        inst_ready_in,
    output logic [31:0] bubble_count_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [31:0]      pc_q;
    logic [31:0]      inflight_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             push;
    logic             pop;
    logic             space;
    logic             req_hs;

    // push counts toward the space rule even when a redirect will drop it
    assign push       = (state == WAIT) && imem_resp_valid_in;
    assign pop        = inst_valid_out && inst_ready_in;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign space      = count_next < DEPTH_C;

    assign imem_req_valid_out = ((state == IDLE) || (state == WAIT && imem_resp_valid_in))
                                && space && !rst_in;
    assign imem_req_addr_out  = pc_q;
    assign req_hs             = imem_req_valid_out && imem_req_ready_in;

    always_comb begin
        state_next = state;
        if (redirect_valid_in) begin
            // a request accepted now fetches the old stream, so its response must be dropped
            if (req_hs)
                state_next = DRAIN;
            else if (state != IDLE && !imem_resp_valid_in)
                state_next = DRAIN;
            else
                state_next = IDLE;
        end else if (req_hs) begin
            state_next = WAIT;
        end else if (imem_resp_valid_in && state != IDLE) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pc_q        <= RESET_PC & ~32'h3;
            inflight_pc <= 32'h0;
        end else begin
            state <= state_next;
            if (req_hs)
                inflight_pc <= pc_q;
            if (redirect_valid_in)
                pc_q <= redirect_pc_in & ~32'h3;
            else if (req_hs)
                pc_q <= pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !redirect_valid_in) begin
            data_mem[wr_ptr] <= imem_resp_data_in;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    assign inst_valid_out = (count != '0);
    assign inst_out       = inst_valid_out ? data_mem[rd_ptr] : NOP;
    assign pc_out         = inst_valid_out ? pc_mem[rd_ptr] : 32'h0;

`ifdef RISCV_FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            bubble_q <= 32'h0;
        else if (!inst_valid_out && bubble_q != 32'hFFFF_FFFF)
            bubble_q <= bubble_q + 32'd1;
    end

    assign bubble_count_out = bubble_q;
`else
    assign bubble_count_out = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: memory model with variable latency, request-order scoreboard,
// directed scenarios followed by randomized traffic with redirects.
module tb_riscv_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] XMASK    = 32'hA5A5_0000;
`ifdef RISCV_FETCH_BUBBLE_CNT_EN
    localparam bit BUB_EN = 1'b1;
`else
    localparam bit BUB_EN = 1'b0;
`endif

    logic        clk_in;
    logic        rst_in;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready_in;
    logic [31:0] bubble_count_out;

    riscv_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_addr_out  (imem_req_addr_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_resp_valid_in (imem_resp_valid_in),
        .imem_resp_data_in  (imem_resp_data_in),
        .redirect_valid_in  (redirect_valid_in),
        .redirect_pc_in     (redirect_pc_in),
        .inst_valid_out     (inst_valid_out),
        .inst_out           (inst_out),
        .pc_out             (pc_out),
        .inst_ready_in      (inst_ready_in),
        .bubble_count_out   (bubble_count_out)
    );

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bexp(input int n);
        return BUB_EN ? 32'(n) : 32'h0;
    endfunction

    // model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_pc;
    logic [31:0] bubble_exp;
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // stimulus controls
    logic        ready_ctl;
    logic        inst_ready_ctl;
    logic        redir_ctl;
    logic [31:0] redir_pc_ctl;
    int          lat_ctl;

    // per-phase logs
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] valid_log[$];
    logic [31:0] reqv_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] inst_log[$];
    logic [31:0] bub_log[$];

    task automatic clear_logs();
        hs_log.delete(); pop_log.delete(); valid_log.delete(); reqv_log.delete();
        pc_log.delete(); inst_log.delete(); bub_log.delete();
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk_in);
        rst_in             = 1'b1;
        imem_req_ready_in  = 1'b0;
        imem_resp_valid_in = 1'b0;
        imem_resp_data_in  = 32'h0;
        redirect_valid_in  = 1'b0;
        redirect_pc_in     = 32'h0;
        inst_ready_in      = 1'b0;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid_out}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid_out}, 32'd0);
        check("rst_inst", inst_out, NOP);
        check("rst_pc", pc_out, 32'h0);
        check("rst_bubble", bubble_count_out, 32'h0);
        repeat (n) @(posedge clk_in);
        exp_q.delete();
        exp_req_pc  = RESET_PC;
        bubble_exp  = 32'h0;
        mem_pending = 1'b0;
        mem_cnt     = 0;
        clear_logs();
    endtask

    // driver: one clock cycle of memory, decoder and redirect activity plus scoreboard update
    task automatic step();
        logic        resp_now;
        logic        hs;
        logic        pop;
        logic [31:0] e;
        @(negedge clk_in);
        rst_in   = 1'b0;
        resp_now = 1'b0;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                resp_now    = 1'b1;
                mem_pending = 1'b0;
            end
        end
        imem_resp_valid_in = resp_now;
        imem_resp_data_in  = resp_now ? (mem_addr ^ XMASK) : $urandom();
        imem_req_ready_in  = ready_ctl;
        inst_ready_in      = inst_ready_ctl;
        redirect_valid_in  = redir_ctl;
        redirect_pc_in     = redir_pc_ctl;
        #1;
        hs  = imem_req_valid_out && imem_req_ready_in;
        pop = inst_valid_out && inst_ready_in && !redirect_valid_in;
        reqv_log.push_back({31'd0, imem_req_valid_out});
        valid_log.push_back({31'd0, inst_valid_out});
        pc_log.push_back(pc_out);
        inst_log.push_back(inst_out);
        bub_log.push_back(bubble_count_out);

        check("bubble", bubble_count_out, bubble_exp);
        if (!inst_valid_out) begin
            check("empty_inst", inst_out, NOP);
            check("empty_pc", pc_out, 32'h0);
        end
        if (hs) begin
            check("one_outstanding", {31'd0, mem_pending}, 32'd0);
            check("req_addr", imem_req_addr_out, exp_req_pc);
            mem_pending = 1'b1;
            mem_cnt     = lat_ctl;
            mem_addr    = imem_req_addr_out;
            exp_q.push_back(exp_req_pc);
            hs_log.push_back(imem_req_addr_out);
            exp_req_pc  = exp_req_pc + 32'd4;
        end
        if (pop) begin
            check("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_pc", pc_out, e);
                check("pop_inst", inst_out, e ^ XMASK);
            end
            pop_log.push_back(pc_out);
        end
        if (redirect_valid_in) begin
            exp_q.delete();
            exp_req_pc = redirect_pc_in & ~32'h3;
        end
        if (BUB_EN && !inst_valid_out && bubble_exp != 32'hFFFF_FFFF)
            bubble_exp = bubble_exp + 32'd1;
    endtask

    task automatic set_ctl(input logic rdy, input logic irdy, input int lat);
        ready_ctl      = rdy;
        inst_ready_ctl = irdy;
        lat_ctl        = lat;
        redir_ctl      = 1'b0;
        redir_pc_ctl   = 32'h0;
    endtask

    initial begin
        bit found;
        int marker;
        int pmark;
        int n4;
        rst_in             = 1'b1;
        imem_req_ready_in  = 1'b0;
        imem_resp_valid_in = 1'b0;
        imem_resp_data_in  = 32'h0;
        redirect_valid_in  = 1'b0;
        redirect_pc_in     = 32'h0;
        inst_ready_in      = 1'b0;
        set_ctl(1'b1, 1'b1, 1);

        // streaming at one instruction per cycle
        apply_reset(2);
        set_ctl(1'b1, 1'b1, 1);
        repeat (6) step();
        check("a_reqv0", reqv_log[0], 32'd1);
        check("a_hs0", hs_log[0], 32'h0);
        check("a_hs1", hs_log[1], 32'h4);
        check("a_hs2", hs_log[2], 32'h8);
        check("a_valid0", valid_log[0], 32'd0);
        check("a_valid1", valid_log[1], 32'd0);
        check("a_valid2", valid_log[2], 32'd1);
        check("a_pc2", pc_log[2], 32'h0);
        check("a_pc3", pc_log[3], 32'h4);
        check("a_pc4", pc_log[4], 32'h8);
        check("a_inst2", inst_log[2], 32'hA5A5_0000);
        check("a_inst3", inst_log[3], 32'hA5A5_0004);
        check("a_bub0", bub_log[0], bexp(0));
        check("a_bub1", bub_log[1], bexp(1));
        check("a_bub3", bub_log[3], bexp(2));

        // decoder stalled: fetch stops when the FIFO would overflow
        apply_reset(1);
        set_ctl(1'b1, 1'b0, 1);
        repeat (6) step();
        for (int i = 2; i < 6; i++) check("b_no_req", reqv_log[i], 32'd0);
        check("b_head_valid", valid_log[5], 32'd1);
        check("b_head_pc", pc_log[5], 32'h0);
        inst_ready_ctl = 1'b1;
        repeat (10) step();
        check("b_pop0", pop_log[0], 32'h0);
        check("b_pop1", pop_log[1], 32'h4);
        check("b_pop2", pop_log[2], 32'h8);

        // redirect while a request is outstanding
        apply_reset(1);
        set_ctl(1'b1, 1'b1, 3);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (hs_log.size() != 0 && hs_log[hs_log.size()-1] == 32'h8) found = 1'b1;
        end
        check("c_found_req8", {31'd0, found}, 32'd1);
        marker = hs_log.size();
        pmark  = pop_log.size();
        redir_ctl    = 1'b1;
        redir_pc_ctl = 32'h0000_0103;
        step();
        redir_ctl = 1'b0;
        step();
        check("c_flushed", valid_log[valid_log.size()-1], 32'd0);
        repeat (20) step();
        check("c_first_req", hs_log[marker], 32'h100);
        check("c_first_pop", pop_log[pmark], 32'h100);
        n4 = 0;
        foreach (pop_log[i]) if (pop_log[i] == 32'h8) n4++;
        check("c_no_pc8", 32'(n4), 32'd0);

        // redirect coinciding with a response, no request accepted that cycle
        apply_reset(1);
        set_ctl(1'b1, 1'b1, 2);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (mem_pending && mem_addr == 32'h4 && mem_cnt == 1) found = 1'b1;
        end
        check("d_found_resp4", {31'd0, found}, 32'd1);
        pmark        = pop_log.size();
        redir_ctl    = 1'b1;
        redir_pc_ctl = 32'h0000_0200;
        ready_ctl    = 1'b0;
        step();
        redir_ctl = 1'b0;
        ready_ctl = 1'b1;
        marker    = hs_log.size();
        step();
        check("d_next_req_cnt", 32'(hs_log.size()), 32'(marker + 1));
        check("d_next_req", hs_log[marker], 32'h200);
        repeat (15) step();
        check("d_first_pop", pop_log[pmark], 32'h200);
        n4 = 0;
        foreach (pop_log[i]) if (pop_log[i] == 32'h4) n4++;
        check("d_no_pc4", 32'(n4), 32'd0);

        // memory not ready, then 3-cycle latency
        apply_reset(1);
        set_ctl(1'b0, 1'b1, 3);
        repeat (5) step();
        check("e_no_hs", 32'(hs_log.size()), 32'd0);
        check("e_reqv", reqv_log[4], 32'd1);
        ready_ctl = 1'b1;
        repeat (40) step();
        for (int i = 0; i < 5; i++) check("e_pop_seq", pop_log[i], 32'(4 * i));

        // reset in the middle of an outstanding request
        apply_reset(1);
        set_ctl(1'b1, 1'b1, 2);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (hs_log.size() >= 2 && mem_pending) found = 1'b1;
        end
        check("f_found_wait", {31'd0, found}, 32'd1);
        apply_reset(1);
        set_ctl(1'b1, 1'b1, 2);
        repeat (5) step();
        check("f_first_req", hs_log[0], RESET_PC);
        check("f_bub0", bub_log[0], bexp(0));
        check("f_bub1", bub_log[1], bexp(1));

        // randomized traffic with redirects
        apply_reset(1);
        set_ctl(1'b1, 1'b1, 1);
        for (int i = 0; i < 1500; i++) begin
            ready_ctl      = ($urandom_range(0, 3) != 0);
            inst_ready_ctl = ($urandom_range(0, 9) < 7);
            lat_ctl        = $urandom_range(1, 3);
            redir_ctl      = ($urandom_range(0, 31) == 0);
            redir_pc_ctl   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : ($urandom() & 32'h0000_3FFF);
            step();
        end
        check("rnd_progress", {31'd0, pop_log.size() > 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
